// File: rtl/auth_decision.sv
// rtl/auth_decision.sv - counts matcher hits per attempt, issues grant/deny, tracks failures.
// Optional lockout after MAX_FAILS consecutive denies is enabled by AUTH_LOCKOUT_EN.
module auth_decision #(
  parameter int TEMPLATE_LEN   = 16,
  parameter int MATCH_THRESH   = 12,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                byte_valid,
  input  logic                                byte_match,
  output logic                                busy,
  output logic                                granted,
  output logic                                denied,
  output logic [$clog2(TEMPLATE_LEN+1)-1:0]   match_count,
  output logic [$clog2(MAX_FAILS+1)-1:0]      fail_count,
  output logic                                locked
);

  localparam int MCW = $clog2(TEMPLATE_LEN + 1);
  localparam int FCW = $clog2(MAX_FAILS + 1);
  localparam logic [MCW-1:0] LEN_C  = MCW'(TEMPLATE_LEN);
  localparam logic [MCW-1:0] THR_C  = MCW'(MATCH_THRESH);
  localparam logic [FCW-1:0] FMAX_C = FCW'(MAX_FAILS);

`ifdef AUTH_LOCKOUT_EN
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DECIDE, S_LOCKOUT} state_t;
  logic [TW-1:0] timer_q, timer_d;
  logic          locked_q, locked_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DECIDE} state_t;
`endif

  state_t         state_q, state_d;
  logic [MCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [MCW-1:0] match_q, match_d;
  logic [FCW-1:0] fail_q, fail_d;
  logic           busy_q, busy_d;
  logic           granted_q, granted_d;
  logic           denied_q, denied_d;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    match_d    = match_q;
    fail_d     = fail_q;
    busy_d     = 1'b0;
    granted_d  = 1'b0;
    denied_d   = 1'b0;
`ifdef AUTH_LOCKOUT_EN
    timer_d    = timer_q;
    locked_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_COLLECT;
          byte_cnt_d = '0;
          match_d    = '0;
          busy_d     = 1'b1;
        end
      end
      S_COLLECT: begin
        busy_d = 1'b1;
        // A restart discards the byte presented in the same cycle.
        if (start) begin
          byte_cnt_d = '0;
          match_d    = '0;
        end else if (byte_valid) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          match_d    = match_q + MCW'(byte_match);
          if (byte_cnt_q == LEN_C - 1'b1) begin
            state_d = S_DECIDE;
          end
        end
      end
      S_DECIDE: begin
        state_d = S_IDLE;
        if (match_q >= THR_C) begin
          granted_d = 1'b1;
          fail_d    = '0;
        end else begin
          denied_d = 1'b1;
`ifdef AUTH_LOCKOUT_EN
          fail_d = fail_q + 1'b1;
          if (fail_q + 1'b1 == FMAX_C) begin
            state_d  = S_LOCKOUT;
            timer_d  = TW'(LOCKOUT_CYCLES);
            locked_d = 1'b1;
          end
`else
          fail_d = (fail_q == FMAX_C) ? fail_q : fail_q + 1'b1;
`endif
        end
      end
`ifdef AUTH_LOCKOUT_EN
      S_LOCKOUT: begin
        // Leaving on the cycle the timer would hit zero gives exactly LOCKOUT_CYCLES locked cycles.
        if (timer_q <= TW'(1)) begin
          state_d = S_IDLE;
          timer_d = '0;
          fail_d  = '0;
        end else begin
          timer_d  = timer_q - 1'b1;
          locked_d = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      match_q    <= '0;
      fail_q     <= '0;
      busy_q     <= 1'b0;
      granted_q  <= 1'b0;
      denied_q   <= 1'b0;
`ifdef AUTH_LOCKOUT_EN
      timer_q    <= '0;
      locked_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      match_q    <= match_d;
      fail_q     <= fail_d;
      busy_q     <= busy_d;
      granted_q  <= granted_d;
      denied_q   <= denied_d;
`ifdef AUTH_LOCKOUT_EN
      timer_q    <= timer_d;
      locked_q   <= locked_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign granted     = granted_q;
  assign denied      = denied_q;
  assign match_count = match_q;
  assign fail_count  = fail_q;
`ifdef AUTH_LOCKOUT_EN
  assign locked      = locked_q;
`else
  assign locked      = 1'b0;
`endif

endmodule

// File: tb/tb_auth_decision.sv
// tb/tb_auth_decision.sv - randomized attempts checked against a transaction-level decision model.
module tb_auth_decision;

  localparam int TL = 16;
  localparam int MT = 12;
  localparam int MF = 3;
  localparam int LC = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       byte_valid = 1'b0;
  logic       byte_match = 1'b0;
  logic       busy, granted, denied, locked;
  logic [4:0] match_count;
  logic [1:0] fail_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_fail = 0;

  auth_decision #(
    .TEMPLATE_LEN(TL), .MATCH_THRESH(MT), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_match(byte_match), .busy(busy), .granted(granted), .denied(denied),
    .match_count(match_count), .fail_count(fail_count), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    int'(busy), 0);
    check({tag, "_granted"}, int'(granted), 0);
    check({tag, "_denied"},  int'(denied), 0);
    check({tag, "_match"},   int'(match_count), 0);
    check({tag, "_fail"},    int'(fail_count), 0);
    check({tag, "_locked"},  int'(locked), 0);
  endtask

  // One full attempt: n_match hits out of TL bytes in shuffled order.
  task automatic do_attempt(input int n_match, input bit gaps, input bit restart, input bit rst_in_lock);
    bit pass_exp, lock_exp;
    int hits;
    bit bits[TL];
    for (int i = 0; i < TL; i++) bits[i] = (i < n_match);
    for (int i = TL - 1; i > 0; i--) begin
      int j;
      bit t;
      j = $urandom_range(0, i);
      t = bits[i]; bits[i] = bits[j]; bits[j] = t;
    end

    start = 1'b1; byte_valid = 1'($urandom); byte_match = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", int'(busy), 1);
    check("start_match_clr", int'(match_count), 0);

    if (restart) begin
      for (int i = 0; i < 5; i++) begin
        byte_valid = 1'b1; byte_match = 1'($urandom);
        step();
      end
      start = 1'b1; byte_valid = 1'b1; byte_match = 1'b1;
      step();
      start = 1'b0;
      check("restart_clr", int'(match_count), 0);
      check("restart_busy", int'(busy), 1);
    end

    hits = 0;
    for (int i = 0; i < TL; i++) begin
      if (gaps) begin
        byte_valid = 1'b0; byte_match = 1'b1;
        step();
      end
      byte_valid = 1'b1; byte_match = bits[i];
      hits += int'(bits[i]);
      step();
    end
    byte_valid = 1'b0; byte_match = 1'b0;
    check("decide_busy", int'(busy), 1);
    check("decide_nopulse", int'(granted | denied), 0);
    check("decide_match", int'(match_count), hits);

    pass_exp = (hits >= MT);
    lock_exp = 1'b0;
    if (pass_exp) exp_fail = 0;
    else begin
      exp_fail++;
`ifdef AUTH_LOCKOUT_EN
      if (exp_fail == MF) lock_exp = 1'b1;
`else
      if (exp_fail > MF) exp_fail = MF;
`endif
    end

    step();
    check("result_granted", int'(granted), int'(pass_exp));
    check("result_denied", int'(denied), int'(!pass_exp));
    check("result_busy", int'(busy), 0);
    check("result_fail", int'(fail_count), exp_fail);
    check("result_locked", int'(locked), int'(lock_exp));
    check("result_match", int'(match_count), hits);

    if (lock_exp && rst_in_lock) begin
      for (int j = 0; j < 5; j++) step();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_lock");
      step();
      rst_n = 1'b1;
      step();
      check("rst_lock_after_locked", int'(locked), 0);
      check("rst_lock_after_pulse", int'(granted | denied), 0);
      exp_fail = 0;
    end else if (lock_exp) begin
      for (int j = 1; j < LC; j++) begin
        start = 1'($urandom); byte_valid = 1'($urandom); byte_match = 1'b1;
        step();
        check("lock_held", int'(locked), 1);
        check("lock_busy", int'(busy), 0);
        check("lock_nopulse", int'(granted | denied), 0);
      end
      start = 1'b1;
      step();
      start = 1'b0; byte_valid = 1'b0;
      exp_fail = 0;
      check("lock_end_locked", int'(locked), 0);
      check("lock_end_fail", int'(fail_count), 0);
      check("lock_end_busy", int'(busy), 0);
    end else begin
      step();
      check("pulse_one_cycle", int'(granted | denied), 0);
    end
  endtask

  initial begin
    int held;
    step();
    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    do_attempt(12, 1'b0, 1'b0, 1'b0);
    do_attempt(11, 1'b0, 1'b0, 1'b0);
    do_attempt(16, 1'b1, 1'b0, 1'b0);

    held = int'(match_count);
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b1; byte_match = 1'b1;
      step();
      check("idle_ignore_match", int'(match_count), held);
      check("idle_ignore_busy", int'(busy), 0);
    end
    byte_valid = 1'b0;

    do_attempt(13, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) do_attempt(10, 1'b0, 1'b0, 1'b0);
    do_attempt(14, 1'b0, 1'b0, 1'b0);

    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      byte_valid = 1'b1; byte_match = 1'b1;
      step();
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_collect");
    byte_valid = 1'b0;
    step();
    rst_n = 1'b1;
    exp_fail = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("rst_collect_nopulse", int'(granted | denied | busy), 0);
    end

`ifdef AUTH_LOCKOUT_EN
    do_attempt(9, 1'b0, 1'b0, 1'b0);
    do_attempt(9, 1'b0, 1'b0, 1'b0);
    do_attempt(9, 1'b0, 1'b0, 1'b1);
    do_attempt(12, 1'b0, 1'b0, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      do_attempt(int'($urandom_range(8, 16)), 1'($urandom), ($urandom_range(0, 7) == 0), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
